pipe_hazard_ctrl: RTL and testbench

Central pipeline sequencer for the 5-stage ARM-subset core. Watches the ID, EXE and MEM stages and drives three control signals: the freeze/flush inputs of the IF/ID stage registers, the bubble insertion into the ID/EXE stage register, and a global freeze while a multi-cycle data-memory access is outstanding. It also keeps a watchdog on memory waits and saturating performance counters for stalls, flushes and freezes.

---
 rtl/pipe_ctrl_pkg.sv | 14 +
 rtl/pipe_hazard_ctrl_hazard_detect.sv | 37 +++
 rtl/pipe_hazard_ctrl.sv | 133 +++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/freeze sequencer.
package pipe_ctrl_pkg;

    localparam int REG_W       = 4;
    localparam int CNT_W_DEF   = 16;
    localparam int TIMEOUT_DEF = 255;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Combinational RAW compare of ID sources against EXE/MEM destinations.
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic             id_valid_i,
    input  logic [REG_W-1:0] id_src1_i,
    input  logic [REG_W-1:0] id_src2_i,
    input  logic             id_two_src_i,
    input  logic             fwd_en_i,
    input  logic             exe_wb_en_i,
    input  logic             exe_mem_read_i,
    input  logic [REG_W-1:0] exe_dest_i,
    input  logic             mem_wb_en_i,
    input  logic [REG_W-1:0] mem_dest_i,
    output logic             raw_o
);

    logic exe_match;
    logic mem_match;

    // Register 0 is an ordinary register here, so all bits take part in the compare.
    assign exe_match = (exe_dest_i == id_src1_i) || (id_two_src_i && (exe_dest_i == id_src2_i));
    assign mem_match = (mem_dest_i == id_src1_i) || (id_two_src_i && (mem_dest_i == id_src2_i));

    always_comb begin
        raw_o = 1'b0;
        if (id_valid_i) begin
            if (fwd_en_i) begin
                // With forwarding only a load in EXE cannot be bypassed in time.
                raw_o = exe_mem_read_i && exe_wb_en_i && exe_match;
            end else begin
                raw_o = (exe_wb_en_i && exe_match) || (mem_wb_en_i && mem_match);
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: stall/flush/freeze generation, memory-wait watchdog, perf counters.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid_i,
    input  logic [REG_W-1:0] id_src1_i,
    input  logic [REG_W-1:0] id_src2_i,
    input  logic             id_two_src_i,
    input  logic             fwd_en_i,
    input  logic             exe_wb_en_i,
    input  logic             exe_mem_read_i,
    input  logic [REG_W-1:0] exe_dest_i,
    input  logic             mem_wb_en_i,
    input  logic [REG_W-1:0] mem_dest_i,
    input  logic             branch_taken_i,
    input  logic             mem_req_i,
    input  logic             mem_ready_i,
    output logic             stall_o,
    output logic             flush_o,
    output logic             freeze_o,
    output logic             err_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o,
    output logic [CNT_W-1:0] freeze_cnt_o
);

    localparam int               WAIT_W   = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              err_q;
    logic [CNT_W-1:0]  stall_cnt_q, flush_cnt_q, freeze_cnt_q;
    logic              raw;
    logic              freeze;

    hazard_detect u_hazard_detect (
        .id_valid_i     (id_valid_i),
        .id_src1_i      (id_src1_i),
        .id_src2_i      (id_src2_i),
        .id_two_src_i   (id_two_src_i),
        .fwd_en_i       (fwd_en_i),
        .exe_wb_en_i    (exe_wb_en_i),
        .exe_mem_read_i (exe_mem_read_i),
        .exe_dest_i     (exe_dest_i),
        .mem_wb_en_i    (mem_wb_en_i),
        .mem_dest_i     (mem_dest_i),
        .raw_o          (raw)
    );

    // The request cycle itself counts as wait 1, so ERROR is entered after TIMEOUT+1 frozen cycles.
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        freeze  = 1'b0;
        unique case (state_q)
            RUN: begin
                wait_d = '0;
                if (mem_req_i && !mem_ready_i) begin
                    freeze  = 1'b1;
                    state_d = MEM_WAIT;
                    wait_d  = WAIT_W'(1);
                end
            end
            MEM_WAIT: begin
                if (mem_ready_i) begin
                    state_d = RUN;
                    wait_d  = '0;
                end else begin
                    freeze = 1'b1;
                    if (wait_q == WAIT_MAX) begin
                        state_d = ERROR;
                    end else begin
                        wait_d = wait_q + WAIT_W'(1);
                    end
                end
            end
            ERROR: begin
                freeze = 1'b1;
            end
            default: begin
                state_d = RUN;
                wait_d  = '0;
            end
        endcase
    end

    assign freeze_o = freeze;
    assign flush_o  = branch_taken_i && !freeze;
    assign stall_o  = raw && !branch_taken_i && !freeze;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            wait_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            err_q   <= (state_d == ERROR);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
            freeze_cnt_q <= '0;
        end else begin
            if (stall_o && (stall_cnt_q != CNT_MAX)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (flush_o && (flush_cnt_q != CNT_MAX)) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
            if (freeze_o && (freeze_cnt_q != CNT_MAX)) begin
                freeze_cnt_q <= freeze_cnt_q + CNT_W'(1);
            end
        end
    end

    assign err_o        = err_q;
    assign stall_cnt_o  = stall_cnt_q;
    assign flush_cnt_o  = flush_cnt_q;
    assign freeze_cnt_o = freeze_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with a small counter width and short timeout.
module tb_pipe_hazard_ctrl;

    localparam int CNT_W   = 4;
    localparam int TIMEOUT = 8;

    logic             clk;
    logic             rst_n;
    logic             id_valid_i;
    logic [3:0]       id_src1_i;
    logic [3:0]       id_src2_i;
    logic             id_two_src_i;
    logic             fwd_en_i;
    logic             exe_wb_en_i;
    logic             exe_mem_read_i;
    logic [3:0]       exe_dest_i;
    logic             mem_wb_en_i;
    logic [3:0]       mem_dest_i;
    logic             branch_taken_i;
    logic             mem_req_i;
    logic             mem_ready_i;
    logic             stall_o;
    logic             flush_o;
    logic             freeze_o;
    logic             err_o;
    logic [CNT_W-1:0] stall_cnt_o;
    logic [CNT_W-1:0] flush_cnt_o;
    logic [CNT_W-1:0] freeze_cnt_o;

    int tests_run;
    int tests_failed;

    pipe_hazard_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .id_valid_i     (id_valid_i),
        .id_src1_i      (id_src1_i),
        .id_src2_i      (id_src2_i),
        .id_two_src_i   (id_two_src_i),
        .fwd_en_i       (fwd_en_i),
        .exe_wb_en_i    (exe_wb_en_i),
        .exe_mem_read_i (exe_mem_read_i),
        .exe_dest_i     (exe_dest_i),
        .mem_wb_en_i    (mem_wb_en_i),
        .mem_dest_i     (mem_dest_i),
        .branch_taken_i (branch_taken_i),
        .mem_req_i      (mem_req_i),
        .mem_ready_i    (mem_ready_i),
        .stall_o        (stall_o),
        .flush_o        (flush_o),
        .freeze_o       (freeze_o),
        .err_o          (err_o),
        .stall_cnt_o    (stall_cnt_o),
        .flush_cnt_o    (flush_cnt_o),
        .freeze_cnt_o   (freeze_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        id_valid_i     = 1'b0;
        id_src1_i      = 4'd0;
        id_src2_i      = 4'd0;
        id_two_src_i   = 1'b0;
        fwd_en_i       = 1'b0;
        exe_wb_en_i    = 1'b0;
        exe_mem_read_i = 1'b0;
        exe_dest_i     = 4'd0;
        mem_wb_en_i    = 1'b0;
        mem_dest_i     = 4'd0;
        branch_taken_i = 1'b0;
        mem_req_i      = 1'b0;
        mem_ready_i    = 1'b0;
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        #12;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        #3;
        tests_run++;
        if ({stall_o, flush_o, freeze_o, err_o} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %b expected 0000", {stall_o, flush_o, freeze_o, err_o});
        end
        tests_run++;
        if ({stall_cnt_o, flush_cnt_o, freeze_cnt_o} !== '0) begin
            tests_failed++;
            $display("FAIL reset_counters: got %0d/%0d/%0d expected 0/0/0", stall_cnt_o, flush_cnt_o, freeze_cnt_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_load_use();
        do_reset();
        id_valid_i = 1'b1; fwd_en_i = 1'b1; exe_mem_read_i = 1'b1;
        exe_wb_en_i = 1'b1; exe_dest_i = 4'd3; id_src1_i = 4'd3;
        #1;
        if (stall_o !== 1'b1) begin tests_failed++; $display("FAIL load_use_stall: got %b expected 1", stall_o); end
        tests_run++;
        if (flush_o !== 1'b0) begin tests_failed++; $display("FAIL load_use_flush: got %b expected 0", flush_o); end
        tests_run++;
        exe_mem_read_i = 1'b0;
        #1;
        if (stall_o !== 1'b0) begin tests_failed++; $display("FAIL load_use_cleared: got %b expected 0", stall_o); end
        tests_run++;
        // Forwarding covers a MEM-stage producer.
        mem_wb_en_i = 1'b1; mem_dest_i = 4'd3;
        #1;
        if (stall_o !== 1'b0) begin tests_failed++; $display("FAIL fwd_mem_hit: got %b expected 0", stall_o); end
        tests_run++;
        idle_inputs();
    endtask

    task automatic test_no_fwd();
        do_reset();
        id_valid_i = 1'b1; mem_wb_en_i = 1'b1; mem_dest_i = 4'd5;
        id_two_src_i = 1'b1; id_src2_i = 4'd5; id_src1_i = 4'd1;
        #1;
        if (stall_o !== 1'b1) begin tests_failed++; $display("FAIL nofwd_mem_src2: got %b expected 1", stall_o); end
        tests_run++;
        id_two_src_i = 1'b0;
        #1;
        if (stall_o !== 1'b0) begin tests_failed++; $display("FAIL nofwd_one_src: got %b expected 0", stall_o); end
        tests_run++;
        idle_inputs();
        id_valid_i = 1'b1; exe_wb_en_i = 1'b1; exe_dest_i = 4'd0; id_src1_i = 4'd0;
        #1;
        if (stall_o !== 1'b1) begin tests_failed++; $display("FAIL nofwd_exe_r0: got %b expected 1", stall_o); end
        tests_run++;
        id_valid_i = 1'b0;
        #1;
        if (stall_o !== 1'b0) begin tests_failed++; $display("FAIL nofwd_invalid: got %b expected 0", stall_o); end
        tests_run++;
        idle_inputs();
    endtask

    task automatic test_branch_hazard();
        do_reset();
        id_valid_i = 1'b1; exe_wb_en_i = 1'b1; exe_dest_i = 4'd7; id_src1_i = 4'd7;
        branch_taken_i = 1'b1;
        #1;
        if (flush_o !== 1'b1) begin tests_failed++; $display("FAIL branch_flush: got %b expected 1", flush_o); end
        tests_run++;
        if (stall_o !== 1'b0) begin tests_failed++; $display("FAIL branch_stall: got %b expected 0", stall_o); end
        tests_run++;
        tick();
        idle_inputs();
        chk("branch_flush_cnt", 32'(flush_cnt_o), 32'd1);
        chk("branch_stall_cnt", 32'(stall_cnt_o), 32'd0);
    endtask

    task automatic test_mem_wait();
        do_reset();
        mem_req_i = 1'b1; mem_ready_i = 1'b0; branch_taken_i = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk($sformatf("memwait_freeze_c%0d", c), 32'(freeze_o), 32'd1);
            chk($sformatf("memwait_flush_c%0d", c), 32'(flush_o), 32'd0);
            tick();
        end
        mem_ready_i = 1'b1;
        #1;
        chk("memwait_freeze_done", 32'(freeze_o), 32'd0);
        chk("memwait_flush_done", 32'(flush_o), 32'd1);
        tick();
        idle_inputs();
        chk("memwait_freeze_cnt", 32'(freeze_cnt_o), 32'd4);
        chk("memwait_flush_cnt", 32'(flush_cnt_o), 32'd1);
        mem_req_i = 1'b1; mem_ready_i = 1'b1;
        #1;
        chk("memwait_ready_now", 32'(freeze_o), 32'd0);
        tick();
        idle_inputs();
        chk("memwait_ready_now_cnt", 32'(freeze_cnt_o), 32'd4);
    endtask

    task automatic test_timeout();
        do_reset();
        mem_req_i = 1'b1; mem_ready_i = 1'b0;
        for (int c = 0; c <= TIMEOUT; c++) begin
            #1;
            chk($sformatf("timeout_freeze_c%0d", c), 32'(freeze_o), 32'd1);
            chk($sformatf("timeout_err_c%0d", c), 32'(err_o), 32'd0);
            tick();
        end
        chk("timeout_err_set", 32'(err_o), 32'd1);
        chk("timeout_freeze_cnt", 32'(freeze_cnt_o), 32'd9);
        mem_req_i = 1'b0; mem_ready_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("timeout_freeze_sticky", 32'(freeze_o), 32'd1);
            chk("timeout_err_sticky", 32'(err_o), 32'd1);
        end
        rst_n = 1'b0;
        #1;
        chk("timeout_reset_err", 32'(err_o), 32'd0);
        chk("timeout_reset_freeze", 32'(freeze_o), 32'd0);
        chk("timeout_reset_cnt", 32'(freeze_cnt_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_ready_at_timeout();
        do_reset();
        mem_req_i = 1'b1; mem_ready_i = 1'b0;
        for (int c = 0; c < TIMEOUT; c++) tick();
        mem_ready_i = 1'b1;
        #1;
        chk("ready_at_limit_freeze", 32'(freeze_o), 32'd0);
        tick();
        idle_inputs();
        #1;
        chk("ready_at_limit_err", 32'(err_o), 32'd0);
        chk("ready_at_limit_run", 32'(freeze_o), 32'd0);
        chk("ready_at_limit_cnt", 32'(freeze_cnt_o), 32'd8);
    endtask

    task automatic test_saturation();
        do_reset();
        id_valid_i = 1'b1; exe_wb_en_i = 1'b1; exe_dest_i = 4'd9; id_src1_i = 4'd9;
        for (int c = 0; c < 14; c++) tick();
        chk("sat_cnt_14", 32'(stall_cnt_o), 32'd14);
        for (int c = 14; c < 20; c++) tick();
        chk("sat_cnt_15", 32'(stall_cnt_o), 32'd15);
        chk("sat_stall_still", 32'(stall_o), 32'd1);
        idle_inputs();
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        idle_inputs();
        test_reset();
        test_load_use();
        test_no_fwd();
        test_branch_hazard();
        test_mem_wait();
        test_timeout();
        test_ready_at_timeout();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
